// File: rtl/collision_detect.sv
// Per-frame dino/obstacle bounding-box test with a grace period and
// an N-consecutive-frame hit filter feeding a sticky collided flag.
module collision_detect #(
   parameter int DINO_W       = 20,
   parameter int DINO_H       = 22,
   parameter int OBS_W        = 12,
   parameter int OBS_H        = 24,
   parameter int HIT_FRAMES   = 2,
   parameter int GRACE_FRAMES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       frame_tick,
   input  logic [9:0] dino_x,
   input  logic [9:0] dino_y,
   input  logic [9:0] obs_x,
   input  logic [9:0] obs_y,
   input  logic       obs_valid,
   output logic       overlap,
   output logic       collided,
   output logic [1:0] det_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRACE = 2'b01,
      ARMED = 2'b10,
      HIT   = 2'b11
   } state_t;

   typedef struct packed {
      logic [9:0]  dx;
      logic [9:0]  dy;
      logic [9:0]  ox;
      logic [9:0]  oy;
      logic [10:0] dr;
      logic [10:0] db;
      logic [10:0] orr;
      logic [10:0] ob;
      logic        ov;
   } edges_t;

   localparam logic [3:0] GF = 4'(GRACE_FRAMES);
   localparam logic [2:0] HF = 3'(HIT_FRAMES);

   state_t     state, state_n;
   logic [3:0] grace_cnt, grace_n;
   logic [2:0] hit_cnt, hit_n;

   logic [9:0] h_dx, h_dy, h_ox, h_oy;
   logic       h_ov, p0, p1, p2;
   edges_t     s1;
   logic       hit_now;

   // Capture coordinates on a frame tick while the detector is active.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_dx <= '0;
         h_dy <= '0;
         h_ox <= '0;
         h_oy <= '0;
         h_ov <= 1'b0;
         p0   <= 1'b0;
      end else begin
         p0 <= start && frame_tick && (state != IDLE);
         if (start && frame_tick && (state != IDLE)) begin
            h_dx <= dino_x;
            h_dy <= dino_y;
            h_ox <= obs_x;
            h_oy <= obs_y;
            h_ov <= obs_valid;
         end
      end
   end

   // Stage 1: right/bottom edges as 11-bit sums so nothing wraps.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         p1 <= 1'b0;
      end else begin
         p1 <= start && p0;
         if (p0) begin
            s1.dx  <= h_dx;
            s1.dy  <= h_dy;
            s1.ox  <= h_ox;
            s1.oy  <= h_oy;
            s1.dr  <= {1'b0, h_dx} + 11'(DINO_W);
            s1.db  <= {1'b0, h_dy} + 11'(DINO_H);
            s1.orr <= {1'b0, h_ox} + 11'(OBS_W);
            s1.ob  <= {1'b0, h_oy} + 11'(OBS_H);
            s1.ov  <= h_ov;
         end
      end
   end

   assign hit_now = s1.ov
                 && ({1'b0, s1.dx} < s1.orr)
                 && ({1'b0, s1.ox} < s1.dr)
                 && ({1'b0, s1.dy} < s1.ob)
                 && ({1'b0, s1.oy} < s1.db);

   // Stage 2: strict-inequality overlap; touching edges do not count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overlap <= 1'b0;
         p2      <= 1'b0;
      end else if (!start) begin
         overlap <= 1'b0;
         p2      <= 1'b0;
      end else begin
         p2 <= p1;
         if (p1) overlap <= hit_now;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         grace_cnt <= '0;
         hit_cnt   <= '0;
      end else begin
         state     <= state_n;
         grace_cnt <= grace_n;
         hit_cnt   <= hit_n;
      end
   end

   // Next state: grace countdown, consecutive-hit filter, sticky HIT.
   always_comb begin
      state_n = state;
      grace_n = grace_cnt;
      hit_n   = hit_cnt;
      if (!start) begin
         state_n = IDLE;
         grace_n = '0;
         hit_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               grace_n = '0;
               hit_n   = '0;
               state_n = (GF == 4'd0) ? ARMED : GRACE;
            end
            GRACE: begin
               if (p2) begin
                  grace_n = grace_cnt + 4'd1;
                  if (grace_n == GF) state_n = ARMED;
               end
            end
            ARMED: begin
               if (p2) begin
                  if (overlap) begin
                     hit_n = hit_cnt + 3'd1;
                     if (hit_n == HF) state_n = HIT;
                  end else begin
                     hit_n = '0;
                  end
               end
            end
            default: begin
               state_n = HIT;
            end
         endcase
      end
   end

   assign collided  = (state == HIT);
   assign det_state = state;

endmodule

// File: tb/tb_collision_detect.sv
// Directed bench for collision_detect: grace, hit filter, touching
// edges, obs_valid masking, restart and asynchronous reset.
module tb_collision_detect;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] dino_x = '0;
   logic [9:0] dino_y = '0;
   logic [9:0] obs_x = '0;
   logic [9:0] obs_y = '0;
   logic       obs_valid = 1'b0;
   logic       overlap;
   logic       collided;
   logic [1:0] det_state;

   int tests = 0;
   int fails = 0;

   collision_detect dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .frame_tick (frame_tick),
      .dino_x     (dino_x),
      .dino_y     (dino_y),
      .obs_x      (obs_x),
      .obs_y      (obs_y),
      .obs_valid  (obs_valid),
      .overlap    (overlap),
      .collided   (collided),
      .det_state  (det_state)
   );

   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic nedge(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic geo(input logic [9:0] ox, input logic v);
      dino_x    = 10'd40;
      dino_y    = 10'd100;
      obs_x     = ox;
      obs_y     = 10'd95;
      obs_valid = v;
   endtask

   initial begin
      // reset asserted: outputs cleared without a clock edge
      #1 reset = 1'b0;
      #4;
      chk("rst_state", 8'(det_state), 8'h0);
      chk("rst_coll", 8'(collided), 8'h0);
      chk("rst_ovl", 8'(overlap), 8'h0);
      nedge(2);
      reset = 1'b1;

      // idle: frame ticks ignored
      geo(10'd50, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         nedge(3);
         chk("idle_state", 8'(det_state), 8'h0);
         chk("idle_coll", 8'(collided), 8'h0);
         chk("idle_ovl", 8'(overlap), 8'h0);
      end

      // start: grace ignores 4 overlapping frames
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("grace_enter", 8'(det_state), 8'h1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         nedge(3);
         chk("grace_state", 8'(det_state), 8'h1);
         chk("grace_cnt", 8'(dut.grace_cnt), 8'(i));
         chk("grace_coll", 8'(collided), 8'h0);
      end
      tick();
      nedge(3);
      chk("armed_enter", 8'(det_state), 8'h2);
      chk("armed_coll", 8'(collided), 8'h0);

      // ticks 5 and 6 overlap: collided exactly 3 edges after tick 6
      tick();
      nedge(3);
      chk("hit1_cnt", 8'(dut.hit_cnt), 8'h1);
      chk("hit1_coll", 8'(collided), 8'h0);
      tick();
      nedge(2);
      chk("lat_k2_coll", 8'(collided), 8'h0);
      nedge(1);
      chk("lat_k3_coll", 8'(collided), 8'h1);
      chk("hit_state", 8'(det_state), 8'h3);
      chk("hit_ovl", 8'(overlap), 8'h1);

      // HIT is sticky over further frames
      geo(10'd200, 1'b1);
      tick();
      nedge(3);
      chk("hit_sticky", 8'(collided), 8'h1);

      // drop start for one cycle: IDLE then GRACE again
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      chk("drop_state", 8'(det_state), 8'h0);
      chk("drop_coll", 8'(collided), 8'h0);
      chk("drop_ovl", 8'(overlap), 8'h0);
      chk("drop_hcnt", 8'(dut.hit_cnt), 8'h0);
      @(negedge clk);
      chk("regrace", 8'(det_state), 8'h1);
      geo(10'd50, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         nedge(3);
      end
      chk("rearmed", 8'(det_state), 8'h2);

      // overlap, touching edge, overlap: hit count 1,0,1
      tick();
      nedge(3);
      chk("seq_a_cnt", 8'(dut.hit_cnt), 8'h1);
      geo(10'd60, 1'b1);
      tick();
      nedge(3);
      chk("touch_ovl", 8'(overlap), 8'h0);
      chk("seq_b_cnt", 8'(dut.hit_cnt), 8'h0);
      geo(10'd50, 1'b1);
      tick();
      nedge(3);
      chk("seq_c_cnt", 8'(dut.hit_cnt), 8'h1);
      chk("seq_coll", 8'(collided), 8'h0);

      // obs_valid low masks overlapping geometry
      geo(10'd50, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         nedge(3);
         chk("nv_ovl", 8'(overlap), 8'h0);
         chk("nv_coll", 8'(collided), 8'h0);
      end
      chk("nv_cnt", 8'(dut.hit_cnt), 8'h0);

      // back-to-back frame ticks
      geo(10'd50, 1'b1);
      @(negedge clk);
      frame_tick = 1'b1;
      nedge(2);
      frame_tick = 1'b0;
      nedge(2);
      chk("b2b_cnt", 8'(dut.hit_cnt), 8'h1);
      chk("b2b_coll0", 8'(collided), 8'h0);
      nedge(1);
      chk("b2b_coll1", 8'(collided), 8'h1);

      // restart, arm, one hit, then reset mid-pipeline
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      nedge(1);
      for (int i = 0; i < 4; i++) begin
         tick();
         nedge(3);
      end
      tick();
      nedge(3);
      chk("pre_rst_cnt", 8'(dut.hit_cnt), 8'h1);
      tick();
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_state", 8'(det_state), 8'h0);
      chk("mid_rst_coll", 8'(collided), 8'h0);
      chk("mid_rst_ovl", 8'(overlap), 8'h0);
      nedge(2);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_coll", 8'(collided), 8'h0);
      end
      chk("post_rst_state", 8'(det_state), 8'h1);
      chk("post_rst_cnt", 8'(dut.hit_cnt), 8'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/collision_detect.md
COLLISION_DETECT -- requirements
Module: collision_detect

Interface
REQ-001 Parameter DINO_W, default 20, dino sprite width in pixels.
REQ-002 Parameter DINO_H, default 22, dino sprite height in pixels.
REQ-003 Parameter OBS_W, default 12, obstacle sprite width in pixels.
REQ-004 Parameter OBS_H, default 24, obstacle sprite height in pixels.
REQ-005 Parameter HIT_FRAMES, default 2, range 1-7, consecutive overlapping frames needed to declare a collision.
REQ-006 Parameter GRACE_FRAMES, default 4, range 0-15, frames ignored after start rises.
REQ-007 clk  input  1  25 MHz system clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-009 start  input  1  game-enable level from the start button; low means the game is idle.
REQ-010 frame_tick  input  1  one-cycle pulse, once per video frame, at the start of vertical blanking.
REQ-011 dino_x, dino_y  input  10 each  dino top-left pixel coordinates.
REQ-012 obs_x, obs_y  input  10 each  obstacle top-left pixel coordinates.
REQ-013 obs_valid  input  1  high when an obstacle is on screen.
REQ-014 overlap  output  1  registered per-frame bounding-box overlap result.
REQ-015 collided  output  1  sticky collision flag, consumed by the game FSM collided input.
REQ-016 det_state  output  2  current FSM state: IDLE=00, GRACE=01, ARMED=10, HIT=11.

Function
REQ-017 Positions and obs_valid shall be sampled into holding registers on the edge where frame_tick=1 (edge k), and only when det_state is not IDLE.
REQ-018 Stage 1 (edge k+1) shall compute the right and bottom edges as 11-bit sums (x+W, y+H), so there is no wrap at 1023.
REQ-019 Stage 2 (edge k+2) shall register overlap = obs_valid AND dino_x<obs_x+OBS_W AND obs_x<dino_x+DINO_W AND dino_y<obs_y+OBS_H AND obs_y<dino_y+DINO_H.
REQ-020 Boxes that only touch (e.g. dino_x+DINO_W == obs_x) shall not count as overlap.
REQ-021 The FSM and counter update (edge k+3) shall use the overlap result of that frame.
REQ-022 Latency from the frame_tick edge to a collided rise shall be exactly 3 clock edges.
REQ-023 The pipeline shall accept a frame_tick on consecutive cycles without stalling.
REQ-024 IDLE: collided=0, counters=0; when start=1, move to GRACE, or to ARMED if GRACE_FRAMES=0.
REQ-025 GRACE: a 4-bit grace counter shall increment on each stage-2 result; at GRACE_FRAMES, move to ARMED; overlap results in GRACE shall be ignored.
REQ-026 ARMED: a 3-bit hit counter shall increment on an overlapping frame and clear to 0 on a non-overlapping frame; on reaching HIT_FRAMES, move to HIT and set collided=1 in the same edge.
REQ-027 HIT: collided shall stay 1 and the counters shall hold; the state shall be left only via start=0 or reset.
REQ-028 start=0 in any state shall move to IDLE on the next edge, clear collided and counters, and discard in-flight pipeline results.
REQ-029 When start rises while a result is in flight, that result shall be discarded; counting begins with the first frame_tick sampled after entering GRACE.
REQ-030 A frame_tick while in IDLE shall be ignored, and overlap shall remain 0.
REQ-031 If start=0 coincides with a pipeline result in the same cycle, start=0 shall win.

Reset
REQ-032 reset=0 shall asynchronously force: det_state=IDLE, overlap=0, collided=0, all counters=0, all holding and pipeline registers=0.
REQ-033 After reset is released, the block shall leave IDLE only on the first rising edge where start=1.
REQ-034 Reset asserted mid-operation, including in HIT, shall override all other inputs.

Verification
REQ-035 Apply reset=0 then release with start=0 and 5 frame_ticks -> det_state=00, collided=0, overlap=0 throughout.
REQ-036 Set start=1 with dino (40,100) and obs (50,95) overlapping, obs_valid=1, for 4 ticks -> GRACE holds, collided=0; ticks 5 and 6 overlap -> collided=1 exactly 3 edges after tick 6.
REQ-037 In ARMED: overlap, then no-overlap (obs_x=60, touching edge), then overlap -> hit counter goes 1,0,1 and collided stays 0.
REQ-038 Overlapping geometry with obs_valid=0 for 10 frames -> overlap=0 and collided=0.
REQ-039 In HIT, drop start for one cycle -> IDLE next edge, collided=0, and the sequence restarts with GRACE.
REQ-040 Assert reset mid-pipeline, 1 cycle after the frame_tick edge -> all outputs 0 immediately, and no late collided after release.
